// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: shared state encoding and constants for the memory bus arbiter
package mem_bus_arbiter_pkg;
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    IF_ACC   = 3'd1,
    IF_DONE  = 3'd2,
    MEM_ACC  = 3'd3,
    MEM_DONE = 3'd4
  } state_t;
  localparam logic CHIP_ENABLE     = 1'b1;
  localparam logic WRITE_ENABLE    = 1'b1;
  localparam int   DEFAULT_TIMEOUT = 255;
endpackage

// File: rtl/mem_bus_arbiter_watchdog.sv
// bus_watchdog: counts cycles spent in an access and flags the cycle that reaches the limit
module bus_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic timeout_o
);
  localparam int W = $clog2(TIMEOUT + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  // cnt holds completed access cycles, so the current cycle is number cnt+1
  assign timeout_o = en && cnt == W'(TIMEOUT - 1);
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory port between fetch and data access, one transaction at a time
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_ce_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              flush_i,
  output logic [DATA_W-1:0] if_inst_o,
  output logic              if_stallreq_o,
  input  logic              mem_ce_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [3:0]        mem_sel_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              mem_stallreq_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [3:0]        bus_sel_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic [DATA_W-1:0] bus_rdata_i,
  input  logic              bus_ack_i,
  output logic              bus_err_o
);
  state_t state, state_n;
  logic flush_pend, flush_pend_n, flushed, timeout, acc;
  logic [DATA_W-1:0] if_inst_n, mem_rdata_n, bus_wdata_n;
  logic [ADDR_W-1:0] bus_addr_n;
  logic [3:0] bus_sel_n;
  logic bus_req_n, bus_we_n, bus_err_n;
  assign acc = state == IF_ACC || state == MEM_ACC;
  assign flushed = flush_pend || flush_i;
  bus_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk(clk),
    .rst(rst),
    .clr(state == IDLE),
    .en(acc),
    .timeout_o(timeout)
  );
  always_comb begin
    state_n = state;
    flush_pend_n = flush_pend;
    if_inst_n = if_inst_o;
    mem_rdata_n = mem_rdata_o;
    bus_req_n = bus_req_o;
    bus_we_n = bus_we_o;
    bus_addr_n = bus_addr_o;
    bus_sel_n = bus_sel_o;
    bus_wdata_n = bus_wdata_o;
    bus_err_n = 1'b0;
    case (state)
      IDLE:
        if (mem_ce_i == CHIP_ENABLE) begin
          state_n = MEM_ACC;
          bus_req_n = 1'b1;
          bus_we_n = mem_we_i;
          bus_addr_n = mem_addr_i;
          bus_sel_n = mem_sel_i;
          bus_wdata_n = mem_wdata_i;
        end else if (if_ce_i == CHIP_ENABLE && !flush_i) begin
          state_n = IF_ACC;
          bus_req_n = 1'b1;
          bus_we_n = 1'b0;
          bus_addr_n = if_addr_i;
          bus_sel_n = 4'b1111;
          bus_wdata_n = '0;
        end
      IF_ACC: begin
        flush_pend_n = flushed;
        if (bus_ack_i || timeout) begin
          state_n = bus_ack_i && flushed ? IDLE : IF_DONE;
          if_inst_n = !bus_ack_i ? '0 : flushed ? if_inst_o : bus_rdata_i;
          bus_err_n = !bus_ack_i;
          flush_pend_n = 1'b0;
        end
      end
      MEM_ACC:
        if (bus_ack_i || timeout) begin
          state_n = MEM_DONE;
          mem_rdata_n = bus_we_o == WRITE_ENABLE ? mem_rdata_o : bus_ack_i ? bus_rdata_i : '0;
          bus_err_n = !bus_ack_i;
        end
      default: state_n = IDLE;
    endcase
    // leaving an access state always ends the bus transaction
    if (acc && state_n != state) begin
      bus_req_n = 1'b0;
      bus_we_n = 1'b0;
      bus_addr_n = '0;
      bus_sel_n = '0;
      bus_wdata_n = '0;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      flush_pend <= 1'b0;
      if_inst_o <= '0;
      mem_rdata_o <= '0;
      bus_req_o <= 1'b0;
      bus_we_o <= 1'b0;
      bus_addr_o <= '0;
      bus_sel_o <= '0;
      bus_wdata_o <= '0;
      bus_err_o <= 1'b0;
    end else begin
      state <= state_n;
      flush_pend <= flush_pend_n;
      if_inst_o <= if_inst_n;
      mem_rdata_o <= mem_rdata_n;
      bus_req_o <= bus_req_n;
      bus_we_o <= bus_we_n;
      bus_addr_o <= bus_addr_n;
      bus_sel_o <= bus_sel_n;
      bus_wdata_o <= bus_wdata_n;
      bus_err_o <= bus_err_n;
    end
  assign if_stallreq_o = !rst && if_ce_i && state != IF_DONE;
  assign mem_stallreq_o = !rst && mem_ce_i && state != MEM_DONE;
endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares the single external memory port between instruction fetch (IF stage / `pc_reg`) and data access (MEM stage) of the five-stage `openmips` core. It sequences one bus transaction at a time with a req/ack handshake, raises per-requester stall requests toward the pipeline controller, and holds returned instruction/data words in registers. It sits between the core's fetch/MEM ports and the top-level memory bus. A watchdog ends hung transactions.

## Interface
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width.
- `TIMEOUT`, 255, maximum cycles in an access state before forced termination.

Ports:
- `clk`  in  1  the only clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `if_ce_i`  in  1  fetch request.
- `if_addr_i`  in  ADDR_W  fetch address.
- `flush_i`  in  1  discard any fetch in progress.
- `if_inst_o`  out  DATA_W  last fetched instruction (registered).
- `if_stallreq_o`  out  1  fetch not yet complete.
- `mem_ce_i`  in  1  data request.
- `mem_we_i`  in  1  1 = store.
- `mem_addr_i`  in  ADDR_W  data address.
- `mem_sel_i`  in  4  byte enables.
- `mem_wdata_i`  in  DATA_W  store data.
- `mem_rdata_o`  out  DATA_W  last load result (registered).
- `mem_stallreq_o`  out  1  data access not yet complete.
- `bus_req_o`  out  1  transaction valid (registered).
- `bus_we_o`, `bus_addr_o`, `bus_sel_o`, `bus_wdata_o`  out  1/ADDR_W/4/DATA_W  latched transaction fields.
- `bus_rdata_i`  in  DATA_W  read data, valid with ack.
- `bus_ack_i`  in  1  single-cycle completion pulse.
- `bus_err_o`  out  1  one-cycle pulse on watchdog timeout.

## Operation
- States: IDLE, IF_ACC, IF_DONE, MEM_ACC, MEM_DONE.
- IDLE:
  - `mem_ce_i` → MEM_ACC. Data has priority because it belongs to the older instruction.
  - Otherwise `if_ce_i && !flush_i` → IF_ACC.
  - Otherwise stay in IDLE.
- On entry to an ACC state, latch the requester's fields into the `bus_*` registers and set `bus_req_o`=1. Fetches drive `bus_we_o`=0 and `bus_sel_o`=4'b1111.
- ACC state on `bus_ack_i`:
  - Go to the matching DONE state.
  - Capture `bus_rdata_i` into `if_inst_o` (fetch) or `mem_rdata_o` (load only; stores leave it unchanged).
  - Clear `bus_req_o` and all `bus_*` fields.
- DONE → IDLE unconditionally. The pipeline advances during DONE, so re-arbitrating there would duplicate the request.
- Stall outputs (combinational):
  - `if_stallreq_o = if_ce_i && state!=IF_DONE`.
  - `mem_stallreq_o = mem_ce_i && state!=MEM_DONE`.
- Flush:
  - `flush_i` in IF_ACC sets a sticky `flush_pend`. The bus transaction still completes and is never aborted.
  - On ack with `flush_pend`, go to IDLE, leave `if_inst_o` unchanged, clear `flush_pend`.
  - `flush_i` has no effect in other states.
- Watchdog:
  - Counter clears on ACC entry and increments each ACC cycle.
  - When the counter reaches TIMEOUT without ack, go to DONE (IF_DONE or MEM_DONE), capture 0 as data, pulse `bus_err_o`.
  - Ack in the same cycle as timeout wins: normal completion, no error.

## Timing
- Reset (async): state IDLE; all outputs 0, including `if_inst_o`, `mem_rdata_o`, `bus_*`, `bus_err_o`; counter and `flush_pend` 0. `bus_req_o` drops without waiting for a clock edge. The memory abandons any transaction when `rst` is asserted.
- Minimum access time: 3 cycles (grant edge, ack edge, DONE→IDLE). An ack in the first ACC cycle is legal.
- `bus_req_o` rises at the edge after the grant decision and stays high until the edge that samples ack.
- A requester sees its stall low for exactly one cycle per completed transaction.
- Requester inputs may change during ACC; the latched bus fields are unaffected.

## Structure
- Shared defines file: state encodings (3-bit), `ZeroWord`, `ChipEnable`/`WriteEnable` macros, default TIMEOUT.
- One natural sub-module: `bus_watchdog`, a clear/enable counter with a `timeout_o` flag.

## Test plan
- Fetch only: `if_addr_i`=0x0000_0004, ack in the 2nd ACC cycle with 0x3401_0020 → `bus_req_o` high for 2 cycles, `if_inst_o`=0x3401_0020, `if_stallreq_o` low for exactly one cycle.
- Simultaneous in IDLE: load at 0x100 and fetch at 0x8 → load issued first, `mem_rdata_o` updated, then fetch at 0x8 issued after IDLE.
- Store: `mem_we_i`=1, `mem_sel_i`=4'b0011, `mem_wdata_i`=0xDEAD_BEEF → `bus_*` match these values, `mem_rdata_o` unchanged.
- `flush_i` pulse during IF_ACC → ack data discarded, FSM returns to IDLE, new `if_addr_i` fetched next.
- No ack → after 255 ACC cycles `bus_err_o` pulses once, DONE entered, data register = 0.
- `rst` asserted mid-MEM_ACC between clock edges → `bus_req_o`, stalls and state cleared immediately.
